// File: rtl/xadac_axi_rd_arb.sv
// Round-robin arbiter sharing one single-beat AXI read channel (AR/R) among NoReq requesters.
// The requester index is prefixed onto the AR ID; R beats are routed back by that prefix.
module xadac_axi_rd_arb #(
  parameter int NoReq     = 2,
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 128,
  parameter int MaxOutst  = 4,
  localparam int SelW     = (NoReq > 1) ? $clog2(NoReq) : 1,
  localparam int MstIdW   = IdWidth + SelW,
  localparam int CntW     = $clog2(MaxOutst + 1)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NoReq-1:0][IdWidth-1:0]       slv_ar_id,
  input  logic [NoReq-1:0][AddrWidth-1:0]     slv_ar_addr,
  input  logic [NoReq-1:0]                    slv_ar_valid,
  output logic [NoReq-1:0]                    slv_ar_ready,
  output logic [NoReq-1:0][IdWidth-1:0]       slv_r_id,
  output logic [NoReq-1:0][DataWidth-1:0]     slv_r_data,
  output logic [NoReq-1:0]                    slv_r_valid,
  input  logic [NoReq-1:0]                    slv_r_ready,
  output logic [MstIdW-1:0]                   mst_ar_id,
  output logic [AddrWidth-1:0]                mst_ar_addr,
  output logic                                mst_ar_valid,
  input  logic                                mst_ar_ready,
  input  logic [MstIdW-1:0]                   mst_r_id,
  input  logic [DataWidth-1:0]                mst_r_data,
  input  logic                                mst_r_valid,
  output logic                                mst_r_ready,
  output logic [NoReq-1:0][CntW-1:0]          outst,
  output logic                                err_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ar_state_e;

  ar_state_e                     state_q, state_d;
  logic [SelW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [MstIdW-1:0]             ar_id_q, ar_id_d;
  logic [AddrWidth-1:0]          ar_addr_q, ar_addr_d;
  logic [NoReq-1:0][CntW-1:0]    outst_q, outst_d;
  logic                          err_q, err_d;

  logic [NoReq-1:0]              eligible;
  logic                          can_load, found, grant;
  int                            win_idx;
  logic [IdWidth-1:0]            win_id;
  logic [AddrWidth-1:0]          win_addr;
  logic [31:0]                   sel_ext;
  logic                          sel_ok, r_hs, unsol;

  // Arbitration: first eligible requester at or above rr_ptr, wrapping at NoReq.
  always_comb begin
    eligible     = '0;
    found        = 1'b0;
    win_idx      = 0;
    win_id       = '0;
    win_addr     = '0;
    slv_ar_ready = '0;
    for (int i = 0; i < NoReq; i++) begin
      eligible[i] = slv_ar_valid[i] && (outst_q[i] < CntW'(MaxOutst));
    end
    can_load = (state_q == EMPTY) || mst_ar_ready;
    for (int k = 0; k < NoReq; k++) begin
      for (int i = 0; i < NoReq; i++) begin
        if (!found && eligible[i] && (i == (int'(rr_ptr_q) + k) % NoReq)) begin
          found   = 1'b1;
          win_idx = i;
        end
      end
    end
    // Gating on rstn keeps the combinational ready low while reset is held.
    grant = rstn && can_load && found;
    for (int i = 0; i < NoReq; i++) begin
      if (i == win_idx) begin
        slv_ar_ready[i] = grant;
        win_id          = slv_ar_id[i];
        win_addr        = slv_ar_addr[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ar_id_d   = ar_id_q;
    ar_addr_d = ar_addr_q;
    if (grant) begin
      state_d   = FULL;
      ar_id_d   = {SelW'(win_idx), win_id};
      ar_addr_d = win_addr;
      rr_ptr_d  = (win_idx + 1 == NoReq) ? '0 : SelW'(win_idx + 1);
    end else if (state_q == FULL && mst_ar_ready) begin
      state_d = EMPTY;
    end
  end

  // R routing by ID prefix; an out-of-range prefix is sunk so the channel never stalls.
  always_comb begin
    sel_ext     = 32'(mst_r_id[MstIdW-1:IdWidth]);
    sel_ok      = sel_ext < 32'(NoReq);
    slv_r_valid = '0;
    slv_r_id    = '0;
    slv_r_data  = '0;
    mst_r_ready = !sel_ok;
    for (int i = 0; i < NoReq; i++) begin
      slv_r_id[i]   = mst_r_id[IdWidth-1:0];
      slv_r_data[i] = mst_r_data;
      if (sel_ext == 32'(i)) begin
        slv_r_valid[i] = mst_r_valid && rstn;
        mst_r_ready    = slv_r_ready[i];
      end
    end
    r_hs = mst_r_valid && mst_r_ready;
  end

  always_comb begin
    outst_d = outst_q;
    unsol   = 1'b0;
    for (int i = 0; i < NoReq; i++) begin
      if (slv_ar_ready[i] && !(r_hs && sel_ext == 32'(i))) begin
        outst_d[i] = outst_q[i] + CntW'(1);
      end else if (!slv_ar_ready[i] && r_hs && sel_ext == 32'(i)) begin
        if (outst_q[i] != '0) outst_d[i] = outst_q[i] - CntW'(1);
      end
      if (r_hs && sel_ext == 32'(i) && outst_q[i] == '0) unsol = 1'b1;
    end
    err_d = err_q || unsol || (r_hs && !sel_ok);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= EMPTY;
      rr_ptr_q  <= '0;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      outst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ar_id_q   <= ar_id_d;
      ar_addr_q <= ar_addr_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
    end
  end

  assign mst_ar_valid = (state_q == FULL);
  assign mst_ar_id    = ar_id_q;
  assign mst_ar_addr  = ar_addr_q;
  assign outst        = outst_q;
  assign err_id       = err_q;

endmodule

// File: tb/tb_xadac_axi_rd_arb.sv
// Directed bench for xadac_axi_rd_arb: a 2-requester instance for the main scenarios and a
// 3-requester instance for the out-of-range ID prefix case.
module tb_xadac_axi_rd_arb;

  logic clk, rstn;
  int n_cmp = 0;
  int n_fail = 0;

  // 2-requester instance (SelW=1, MstIdW=5, CntW=3)
  logic [1:0][3:0]  s_ar_id;
  logic [1:0][31:0] s_ar_addr;
  logic [1:0]       s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [1:0][3:0]  s_r_id;
  logic [1:0][31:0] s_r_data;
  logic [4:0]       m_ar_id, m_r_id;
  logic [31:0]      m_ar_addr, m_r_data;
  logic             m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, err;
  logic [1:0][2:0]  outst;

  // 3-requester instance (SelW=2, MstIdW=6, CntW=3)
  logic [2:0][3:0]  t_ar_id;
  logic [2:0][31:0] t_ar_addr;
  logic [2:0]       t_ar_valid, t_ar_ready, t_r_valid, t_r_ready;
  logic [2:0][3:0]  t_r_id;
  logic [2:0][31:0] t_r_data;
  logic [5:0]       t_m_ar_id, t_m_r_id;
  logic [31:0]      t_m_ar_addr, t_m_r_data;
  logic             t_m_ar_valid, t_m_ar_ready, t_m_r_valid, t_m_r_ready, t_err;
  logic [2:0][2:0]  t_outst;

  xadac_axi_rd_arb #(.NoReq(2), .IdWidth(4), .AddrWidth(32), .DataWidth(32), .MaxOutst(4)) dut (
    .clk(clk), .rstn(rstn),
    .slv_ar_id(s_ar_id), .slv_ar_addr(s_ar_addr), .slv_ar_valid(s_ar_valid), .slv_ar_ready(s_ar_ready),
    .slv_r_id(s_r_id), .slv_r_data(s_r_data), .slv_r_valid(s_r_valid), .slv_r_ready(s_r_ready),
    .mst_ar_id(m_ar_id), .mst_ar_addr(m_ar_addr), .mst_ar_valid(m_ar_valid), .mst_ar_ready(m_ar_ready),
    .mst_r_id(m_r_id), .mst_r_data(m_r_data), .mst_r_valid(m_r_valid), .mst_r_ready(m_r_ready),
    .outst(outst), .err_id(err)
  );

  xadac_axi_rd_arb #(.NoReq(3), .IdWidth(4), .AddrWidth(32), .DataWidth(32), .MaxOutst(4)) dut3 (
    .clk(clk), .rstn(rstn),
    .slv_ar_id(t_ar_id), .slv_ar_addr(t_ar_addr), .slv_ar_valid(t_ar_valid), .slv_ar_ready(t_ar_ready),
    .slv_r_id(t_r_id), .slv_r_data(t_r_data), .slv_r_valid(t_r_valid), .slv_r_ready(t_r_ready),
    .mst_ar_id(t_m_ar_id), .mst_ar_addr(t_m_ar_addr), .mst_ar_valid(t_m_ar_valid), .mst_ar_ready(t_m_ar_ready),
    .mst_r_id(t_m_r_id), .mst_r_data(t_m_r_data), .mst_r_valid(t_m_r_valid), .mst_r_ready(t_m_r_ready),
    .outst(t_outst), .err_id(t_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    s_ar_id = '0; s_ar_addr = '0; s_ar_valid = '0; s_r_ready = 2'b11;
    m_ar_ready = 1'b1; m_r_id = '0; m_r_data = '0; m_r_valid = 1'b0;
    t_ar_id = '0; t_ar_addr = '0; t_ar_valid = '0; t_r_ready = 3'b111;
    t_m_ar_ready = 1'b1; t_m_r_id = '0; t_m_r_data = '0; t_m_r_valid = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    s_ar_valid = 2'b11; m_r_valid = 1'b1;
    #1;
    n_cmp++; if (s_ar_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ar_ready got=%b exp=00", s_ar_ready); end
    n_cmp++; if (s_r_valid !== 2'b00) begin n_fail++; $display("FAIL rst_r_valid got=%b exp=00", s_r_valid); end
    n_cmp++; if (m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ar_valid got=%b exp=0", m_ar_valid); end
    n_cmp++; if (m_ar_id !== 5'd0 || m_ar_addr !== 32'd0) begin n_fail++; $display("FAIL rst_ar_reg got=%h/%h exp=0/0", m_ar_id, m_ar_addr); end
    n_cmp++; if (outst !== 6'd0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_err got=%h/%b exp=0/0", outst, err); end
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    @(negedge clk);
    s_ar_valid = 2'b01; s_ar_id[0] = 4'd3; s_ar_addr[0] = 32'h1000;
    #1;
    n_cmp++; if (s_ar_ready !== 2'b01) begin n_fail++; $display("FAIL single_ar_ready got=%b exp=01", s_ar_ready); end
    @(negedge clk);
    s_ar_valid = 2'b00;
    #1;
    n_cmp++; if (m_ar_valid !== 1'b1 || m_ar_id !== 5'b00011 || m_ar_addr !== 32'h1000)
      begin n_fail++; $display("FAIL single_ar_out got=%b/%b/%h exp=1/00011/1000", m_ar_valid, m_ar_id, m_ar_addr); end
    n_cmp++; if (outst[0] !== 3'd1) begin n_fail++; $display("FAIL single_outst_inc got=%0d exp=1", outst[0]); end
    m_r_valid = 1'b1; m_r_id = 5'b00011; m_r_data = 32'hdeadbeef;
    #1;
    n_cmp++; if (s_r_valid !== 2'b01 || s_r_id[0] !== 4'd3 || s_r_data[0] !== 32'hdeadbeef)
      begin n_fail++; $display("FAIL single_r_route got=%b/%h/%h exp=01/3/deadbeef", s_r_valid, s_r_id[0], s_r_data[0]); end
    n_cmp++; if (m_r_ready !== 1'b1) begin n_fail++; $display("FAIL single_r_ready got=%b exp=1", m_r_ready); end
    @(negedge clk);
    m_r_valid = 1'b0;
    #1;
    n_cmp++; if (outst[0] !== 3'd0) begin n_fail++; $display("FAIL single_outst_dec got=%0d exp=0", outst[0]); end
    n_cmp++; if (m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", m_ar_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [4];
    logic [4:0] exp_id [4];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_id  = '{5'b00001, 5'b10010, 5'b00001, 5'b10010};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        s_ar_valid = 2'b11; s_ar_id[0] = 4'd1; s_ar_id[1] = 4'd2;
        s_ar_addr[0] = 32'h100; s_ar_addr[1] = 32'h200;
      end
      #1;
      n_cmp++; if (s_ar_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL rr_grant%0d got=%b exp=%b", k, s_ar_ready, exp_rdy[k]); end
      if (k > 0) begin
        n_cmp++; if (m_ar_valid !== 1'b1 || m_ar_id !== exp_id[k-1])
          begin n_fail++; $display("FAIL rr_ar%0d got=%b/%b exp=1/%b", k, m_ar_valid, m_ar_id, exp_id[k-1]); end
      end
    end
    @(negedge clk);
    s_ar_valid = 2'b00;
    #1;
    n_cmp++; if (m_ar_valid !== 1'b1 || m_ar_id !== 5'b10010 || m_ar_addr !== 32'h200)
      begin n_fail++; $display("FAIL rr_last got=%b/%b/%h exp=1/10010/200", m_ar_valid, m_ar_id, m_ar_addr); end
    n_cmp++; if (outst !== {3'd2, 3'd2}) begin n_fail++; $display("FAIL rr_outst got=%h exp=%h", outst, {3'd2, 3'd2}); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(negedge clk);
    m_ar_ready = 1'b0;
    s_ar_valid = 2'b11; s_ar_id[0] = 4'd5; s_ar_id[1] = 4'd6;
    s_ar_addr[0] = 32'hA0; s_ar_addr[1] = 32'hB0;
    #1;
    n_cmp++; if (s_ar_ready !== 2'b01) begin n_fail++; $display("FAIL bp_first got=%b exp=01", s_ar_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (s_ar_ready !== 2'b00 || m_ar_valid !== 1'b1 || m_ar_id !== 5'b00101 || m_ar_addr !== 32'hA0)
        begin n_fail++; $display("FAIL bp_hold%0d got=%b/%b/%b/%h exp=00/1/00101/a0", k, s_ar_ready, m_ar_valid, m_ar_id, m_ar_addr); end
    end
    @(negedge clk);
    m_ar_ready = 1'b1;
    #1;
    n_cmp++; if (s_ar_ready !== 2'b10) begin n_fail++; $display("FAIL bp_release got=%b exp=10", s_ar_ready); end
    @(negedge clk);
    s_ar_valid = 2'b00;
    #1;
    n_cmp++; if (m_ar_id !== 5'b10110 || m_ar_addr !== 32'hB0)
      begin n_fail++; $display("FAIL bp_next got=%b/%h exp=10110/b0", m_ar_id, m_ar_addr); end
  endtask

  task automatic test_outst_cap();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_ar_valid = 2'b10; s_ar_id[1] = 4'd7; s_ar_addr[1] = 32'h300;
      #1;
      n_cmp++; if (s_ar_ready !== 2'b10) begin n_fail++; $display("FAIL cap_grant%0d got=%b exp=10", k, s_ar_ready); end
    end
    @(negedge clk);
    s_ar_valid = 2'b11;
    #1;
    n_cmp++; if (outst[1] !== 3'd4) begin n_fail++; $display("FAIL cap_full got=%0d exp=4", outst[1]); end
    n_cmp++; if (s_ar_ready !== 2'b01) begin n_fail++; $display("FAIL cap_block got=%b exp=01", s_ar_ready); end
    @(negedge clk);
    s_ar_valid = 2'b10;
    m_r_valid = 1'b1; m_r_id = 5'b10111;
    #1;
    n_cmp++; if (s_r_valid !== 2'b10 || s_ar_ready !== 2'b00)
      begin n_fail++; $display("FAIL cap_r got=%b/%b exp=10/00", s_r_valid, s_ar_ready); end
    @(negedge clk);
    m_r_valid = 1'b0;
    #1;
    n_cmp++; if (outst[1] !== 3'd3 || s_ar_ready !== 2'b10)
      begin n_fail++; $display("FAIL cap_reopen got=%0d/%b exp=3/10", outst[1], s_ar_ready); end
    @(negedge clk);
    s_ar_valid = 2'b00;
    #1;
    n_cmp++; if (outst[1] !== 3'd4) begin n_fail++; $display("FAIL cap_refill got=%0d exp=4", outst[1]); end
  endtask

  task automatic test_r_backpressure();
    apply_reset();
    @(negedge clk);
    s_ar_valid = 2'b10; s_ar_id[1] = 4'd2; s_ar_addr[1] = 32'h40;
    #1;
    n_cmp++; if (s_ar_ready !== 2'b10) begin n_fail++; $display("FAIL rbp_grant got=%b exp=10", s_ar_ready); end
    @(negedge clk);
    s_ar_valid = 2'b00; s_r_ready = 2'b01;
    m_r_valid = 1'b1; m_r_id = 5'b10010;
    #1;
    n_cmp++; if (m_r_ready !== 1'b0 || s_r_valid !== 2'b10)
      begin n_fail++; $display("FAIL rbp_stall got=%b/%b exp=0/10", m_r_ready, s_r_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if (outst[1] !== 3'd1) begin n_fail++; $display("FAIL rbp_hold got=%0d exp=1", outst[1]); end
    s_r_ready = 2'b11; s_ar_valid = 2'b10;
    #1;
    n_cmp++; if (s_ar_ready !== 2'b10 || m_r_ready !== 1'b1)
      begin n_fail++; $display("FAIL rbp_both got=%b/%b exp=10/1", s_ar_ready, m_r_ready); end
    @(negedge clk);
    s_ar_valid = 2'b00; m_r_valid = 1'b0;
    #1;
    n_cmp++; if (outst[1] !== 3'd1) begin n_fail++; $display("FAIL rbp_simul got=%0d exp=1", outst[1]); end
  endtask

  task automatic test_error_reset();
    apply_reset();
    @(negedge clk);
    t_m_r_valid = 1'b1; t_m_r_id = 6'b110001;
    #1;
    n_cmp++; if (t_m_r_ready !== 1'b1 || t_r_valid !== 3'b000 || t_err !== 1'b0)
      begin n_fail++; $display("FAIL err_sink got=%b/%b/%b exp=1/000/0", t_m_r_ready, t_r_valid, t_err); end
    @(negedge clk);
    t_m_r_valid = 1'b0;
    m_ar_ready = 1'b0; s_ar_valid = 2'b01; s_ar_id[0] = 4'd1; s_ar_addr[0] = 32'h40;
    #1;
    n_cmp++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL err_prefix got=%b exp=1", t_err); end
    @(negedge clk);
    s_ar_valid = 2'b00;
    #1;
    n_cmp++; if (m_ar_valid !== 1'b1 || outst[0] !== 3'd1)
      begin n_fail++; $display("FAIL err_inflight got=%b/%0d exp=1/1", m_ar_valid, outst[0]); end
    m_r_valid = 1'b1; m_r_id = 5'b10000;
    #1;
    n_cmp++; if (s_r_valid !== 2'b10) begin n_fail++; $display("FAIL err_unsol_route got=%b exp=10", s_r_valid); end
    @(negedge clk);
    m_r_valid = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b1 || outst[1] !== 3'd0)
      begin n_fail++; $display("FAIL err_unsol got=%b/%0d exp=1/0", err, outst[1]); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0 || t_err !== 1'b0 || outst !== 6'd0 || m_ar_valid !== 1'b0)
      begin n_fail++; $display("FAIL err_async_rst got=%b/%b/%h/%b exp=0/0/0/0", err, t_err, outst, m_ar_valid); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_outst_cap();
    test_r_backpressure();
    test_error_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
